// File: rtl/servo_pkg.sv
// Shared constants, status payload layout and width clamp for the servo PWM bank.
package servo_pkg;

  localparam int unsigned NUM_CH = 6;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned US_W   = 16;
  localparam int unsigned OFS_W  = 3;
  localparam int unsigned WIN_SZ = 8;

  localparam logic [OFS_W-1:0] OFS_EN     = 3'd6;
  localparam logic [OFS_W-1:0] OFS_STATUS = 3'd7;

  localparam int unsigned DEF_BASE_ADDR    = 32'h0000_0F00;
  localparam int unsigned DEF_TICKS_PER_US = 50;
  localparam int unsigned DEF_FRAME_US     = 20000;
  localparam int unsigned DEF_MIN_US       = 500;
  localparam int unsigned DEF_MAX_US       = 2500;
  localparam int unsigned DEF_CENTER_US    = 1500;

  // Read-only status word: frame position in the upper half, frame counter in the lower.
  typedef struct packed {
    logic [US_W-1:0] frame_us;
    logic [US_W-1:0] frame_cnt;
  } status_t;

  // Saturate a written width into the legal servo range.
  function automatic logic [US_W-1:0] clamp_us(input logic [US_W-1:0] v,
                                               input logic [US_W-1:0] lo,
                                               input logic [US_W-1:0] hi);
    logic [US_W-1:0] r;
    r = v;
    if (v < lo) r = lo;
    else if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/servo_timebase.sv
// Microsecond prescaler and frame position counter for the servo PWM bank.
module servo_timebase
  import servo_pkg::*;
#(
  parameter int unsigned TICKS_PER_US = DEF_TICKS_PER_US,
  parameter int unsigned FRAME_US     = DEF_FRAME_US
) (
  input  logic            clock,
  input  logic            reset,
  output logic            tick_c,
  output logic            frame_start_c,
  output logic [US_W-1:0] frame_us
);

  localparam int unsigned PRE_W = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;

  logic [PRE_W-1:0] prescale;

  assign tick_c        = (prescale == PRE_W'(TICKS_PER_US - 1));
  assign frame_start_c = tick_c && (frame_us == US_W'(FRAME_US - 1));

  // Prescaler: one tick per microsecond.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) prescale <= '0;
    else if (tick_c) prescale <= '0;
    else prescale <= prescale + PRE_W'(1);
  end

  // Frame position in microseconds, wrapping at the frame length.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) frame_us <= '0;
    else if (tick_c) frame_us <= frame_start_c ? '0 : frame_us + US_W'(1);
  end

endmodule

// File: rtl/servo_pwm_bank.sv
// Memory-mapped six-channel servo PWM generator with frame-aligned width/enable updates.
module servo_pwm_bank
  import servo_pkg::*;
#(
  parameter int unsigned BASE_ADDR    = DEF_BASE_ADDR,
  parameter int unsigned TICKS_PER_US = DEF_TICKS_PER_US,
  parameter int unsigned FRAME_US     = DEF_FRAME_US,
  parameter int unsigned MIN_US       = DEF_MIN_US,
  parameter int unsigned MAX_US       = DEF_MAX_US,
  parameter int unsigned CENTER_US    = DEF_CENTER_US
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wren,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] rdata,
  output logic              sel,
  output logic              servo1,
  output logic              servo2,
  output logic              servo3,
  output logic              servo4,
  output logic              servo5,
  output logic              servo6
);

  logic [US_W-1:0]   shadow_w [NUM_CH];
  logic [US_W-1:0]   active_w [NUM_CH];
  logic [NUM_CH-1:0] shadow_en;
  logic [NUM_CH-1:0] active_en;
  logic [US_W-1:0]   frame_cnt;
  logic [US_W-1:0]   frame_us;
  logic [NUM_CH-1:0] servo_q;
  logic [NUM_CH-1:0] cmp_c;
  logic [ADDR_W-1:0] ofs_c;
  logic [OFS_W-1:0]  reg_ofs_c;
  logic [DATA_W-1:0] rd_c;
  logic              tick_c;
  logic              frame_start_c;
  status_t           status_c;
  logic              unused_bits;

  servo_timebase #(
    .TICKS_PER_US(TICKS_PER_US),
    .FRAME_US    (FRAME_US)
  ) u_timebase (
    .clock        (clock),
    .reset        (reset),
    .tick_c       (tick_c),
    .frame_start_c(frame_start_c),
    .frame_us     (frame_us)
  );

  // Upper store bits and the raw tick carry no register state here.
  assign unused_bits = ^{data[DATA_W-1:US_W], tick_c};

  // Address window decode; modular subtraction rejects addresses below the base.
  assign ofs_c     = address - ADDR_W'(BASE_ADDR);
  assign sel       = (ofs_c < ADDR_W'(WIN_SZ));
  assign reg_ofs_c = ofs_c[OFS_W-1:0];

  assign status_c.frame_us  = frame_us;
  assign status_c.frame_cnt = frame_cnt;

  // Shadow register file: processor stores land here immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) shadow_w[i] <= US_W'(CENTER_US);
      shadow_en <= '0;
    end else if (wren && sel) begin
      if (reg_ofs_c < OFS_W'(NUM_CH))
        shadow_w[reg_ofs_c] <= clamp_us(data[US_W-1:0], US_W'(MIN_US), US_W'(MAX_US));
      else if (reg_ofs_c == OFS_EN)
        shadow_en <= data[NUM_CH-1:0];
    end
  end

  // Active copy and frame counter update only at the frame boundary.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) active_w[i] <= US_W'(CENTER_US);
      active_en <= '0;
      frame_cnt <= '0;
    end else if (frame_start_c) begin
      for (int i = 0; i < NUM_CH; i++) active_w[i] <= shadow_w[i];
      active_en <= shadow_en;
      frame_cnt <= frame_cnt + US_W'(1);
    end
  end

  // Read-back source selection for the addressed register.
  always_comb begin
    rd_c = '0;
    if (reg_ofs_c < OFS_W'(NUM_CH)) rd_c = DATA_W'(shadow_w[reg_ofs_c]);
    else if (reg_ofs_c == OFS_EN)   rd_c = DATA_W'(shadow_en);
    else                            rd_c = status_c;
  end

  // Registered read data, zero when the previous address was outside the window.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rdata <= '0;
    else rdata <= sel ? rd_c : '0;
  end

  // Per-channel pulse comparators.
  always_comb begin
    cmp_c = '0;
    for (int i = 0; i < NUM_CH; i++) cmp_c[i] = active_en[i] & (frame_us < active_w[i]);
  end

  // Registered PWM outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) servo_q <= '0;
    else servo_q <= cmp_c;
  end

  assign servo1 = servo_q[0];
  assign servo2 = servo_q[1];
  assign servo3 = servo_q[2];
  assign servo4 = servo_q[3];
  assign servo5 = servo_q[4];
  assign servo6 = servo_q[5];

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Directed bench for servo_pwm_bank with a shortened frame (2 ticks/us, 3000 us frame).
module tb_servo_pwm_bank;

  logic        clock = 1'b0;
  logic        reset;
  logic        wren;
  logic [11:0] address;
  logic [31:0] data;
  logic [31:0] rdata;
  logic        sel;
  logic        servo1, servo2, servo3, servo4, servo5, servo6;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int others_hi = 0;

  servo_pwm_bank #(
    .TICKS_PER_US(2),
    .FRAME_US    (3000)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .wren   (wren),
    .address(address),
    .data   (data),
    .rdata  (rdata),
    .sel    (sel),
    .servo1 (servo1),
    .servo2 (servo2),
    .servo3 (servo3),
    .servo4 (servo4),
    .servo5 (servo5),
    .servo6 (servo6)
  );

  always #5 clock = ~clock;

  // Free-running posedge counter for absolute timing checks.
  always @(posedge clock) cyc <= cyc + 1;

  // Channels 2-6 are never enabled, so any high sample is an error.
  always @(negedge clock)
    if (reset && (servo2 || servo3 || servo4 || servo5 || servo6)) others_hi <= others_hi + 1;

  typedef struct packed {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        exp_sel;
    logic        chk_rd;
    logic [31:0] rd_mask;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic w, input logic [11:0] a, input logic [31:0] d,
                     input logic s, input logic c, input logic [31:0] m, input logic [31:0] e);
    vec_t v;
    v = '{wr: w, addr: a, wdata: d, exp_sel: s, chk_rd: c, rd_mask: m, exp_rd: e};
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
    end
  endtask

  // Wait (sampling on negedges) until servo1 equals lvl; n = samples spent waiting.
  task automatic wait_servo(input logic lvl, input int bound, output int n, output bit to);
    n  = 0;
    to = 1'b1;
    for (int i = 0; i < bound; i++) begin
      if (servo1 === lvl) begin
        to = 1'b0;
        break;
      end
      @(negedge clock);
      n++;
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    wren = 1'b1; address = a; data = d;
    @(negedge clock);
    wren = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] v);
    wren = 1'b0; address = a;
    @(negedge clock);
    v = rdata;
  endtask

  initial begin
    vec_t        v;
    int          rel;
    int          n;
    int          hi;
    int          lo;
    bit          to;
    logic [31:0] r;

    reset = 1'b0; wren = 1'b0; address = 12'h000; data = 32'h0;

    //   wr    addr     wdata          sel  chk  mask           expected
    add(1'b0, 12'hF00, 32'd0,          1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1500);
    add(1'b0, 12'hF06, 32'd0,          1'b1, 1'b1, 32'hFFFF_FFFF, 32'd0);
    add(1'b1, 12'hF00, 32'd1000,       1'b1, 1'b0, 32'h0,         32'd0);
    add(1'b1, 12'hF06, 32'hFFFF_FF01,  1'b1, 1'b0, 32'h0,         32'd0);
    add(1'b1, 12'hF01, 32'd100,        1'b1, 1'b0, 32'h0,         32'd0);
    add(1'b1, 12'hF02, 32'd9999,       1'b1, 1'b0, 32'h0,         32'd0);
    add(1'b1, 12'hF03, 32'd0,          1'b1, 1'b0, 32'h0,         32'd0);
    add(1'b0, 12'hF00, 32'd0,          1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1000);
    add(1'b0, 12'hF01, 32'd0,          1'b1, 1'b1, 32'hFFFF_FFFF, 32'd500);
    add(1'b0, 12'hF02, 32'd0,          1'b1, 1'b1, 32'hFFFF_FFFF, 32'd2500);
    add(1'b0, 12'hF03, 32'd0,          1'b1, 1'b1, 32'hFFFF_FFFF, 32'd500);
    add(1'b0, 12'hF06, 32'd0,          1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1);
    add(1'b1, 12'hEFF, 32'd123,        1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0);
    add(1'b1, 12'hF08, 32'd123,        1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0);
    add(1'b0, 12'hF04, 32'd0,          1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1500);
    add(1'b0, 12'hF01, 32'd0,          1'b1, 1'b1, 32'hFFFF_FFFF, 32'd500);
    add(1'b1, 12'hF07, 32'h1234_5678,  1'b1, 1'b0, 32'h0,         32'd0);
    add(1'b0, 12'hF07, 32'd0,          1'b1, 1'b1, 32'h0000_FFFF, 32'd0);
    add(1'b0, 12'hF05, 32'd0,          1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1500);
    add(1'b0, 12'hF09, 32'd0,          1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0);

    // Reset state
    repeat (3) @(negedge clock);
    check("reset_servos", {26'd0, servo6, servo5, servo4, servo3, servo2, servo1}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    reset = 1'b1;
    rel = cyc;

    // Register access table, one clock per vector
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      wren = v.wr; address = v.addr; data = v.wdata;
      #1;
      check($sformatf("vec%0d_sel", i), {31'd0, sel}, {31'd0, v.exp_sel});
      @(negedge clock);
      wren = 1'b0;
      if (v.chk_rd) check($sformatf("vec%0d_rdata", i), rdata & v.rd_mask, v.exp_rd);
    end

    // First frame runs with enables cleared; servo1 rises one cycle after the first frame_start
    wait_servo(1'b1, 14000, n, to);
    check("first_rise_timeout", {31'd0, to}, 32'd0);
    check("first_rise_cycle", 32'(cyc - rel), 32'd6001);
    wait_servo(1'b0, 7000, hi, to);
    check("f1_high_cycles", 32'(hi), 32'd2000);
    wait_servo(1'b1, 7000, lo, to);
    check("f1_low_cycles", 32'(lo), 32'd4000);

    // Store 2000 exactly on the next frame_start edge
    repeat (5998) @(posedge clock);
    @(negedge clock);
    wr(12'hF00, 32'd2000);
    wait_servo(1'b1, 14000, n, to);
    check("f3_rise_timeout", {31'd0, to}, 32'd0);
    wait_servo(1'b0, 7000, hi, to);
    check("f3_high_cycles_old_width", 32'(hi), 32'd2000);
    wait_servo(1'b1, 7000, lo, to);
    check("f3_low_cycles", 32'(lo), 32'd4000);

    // Clear the mask mid-pulse: pulse completes at the new 2000 us width
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      if (servo1) hi++;
      @(negedge clock);
    end
    if (servo1) hi++;
    wr(12'hF06, 32'd0);
    wait_servo(1'b0, 7000, n, to);
    hi += n;
    check("f4_high_cycles_full", 32'(hi), 32'd4000);
    wait_servo(1'b1, 7000, n, to);
    check("f5_stays_low", {31'd0, to}, 32'd1);

    // Status is read-only
    rd(12'hF07, r);
    check("frame_cnt_before", r & 32'h0000_FFFF, 32'd5);
    wr(12'hF07, 32'hFFFF_FFFF);
    rd(12'hF07, r);
    check("frame_cnt_after_store", r & 32'h0000_FFFF, 32'd5);
    rd(12'hF06, r);
    check("mask_cleared", r, 32'd0);
    rd(12'hF00, r);
    check("width0_2000", r, 32'd2000);

    // Async reset while servo1 is high
    wr(12'hF06, 32'd1);
    wait_servo(1'b1, 14000, n, to);
    check("pre_reset_rise_timeout", {31'd0, to}, 32'd0);
    repeat (50) @(negedge clock);
    check("pre_reset_high", {31'd0, servo1}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_reset_servo1", {31'd0, servo1}, 32'd0);
    check("async_reset_rdata", rdata, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    rd(12'hF07, r);
    check("post_reset_frame_cnt", r & 32'h0000_FFFF, 32'd0);
    rd(12'hF00, r);
    check("post_reset_width0", r, 32'd1500);
    rd(12'hF06, r);
    check("post_reset_mask", r, 32'd0);
    repeat (20) @(negedge clock);
    check("post_reset_servo1", {31'd0, servo1}, 32'd0);

    check("other_channels_high_samples", 32'(others_hi), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
